regfile: RTL and testbench

General-purpose register file for the single-cycle and pipelined CPU datapath: 32 registers of 32 bits, two combinational read ports and one synchronous write port. Register 0 is hardwired to zero, MIPS-style. It sits between instruction decode, which supplies the read addresses, and writeback, which supplies the write address, data and enable.

---
 rtl/regfile.sv | 36 +++
 tb/tb_regfile.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 2^ADDR_WIDTH x DATA_WIDTH register file: two combinational read ports, one
// synchronous write port, entry 0 hardwired to zero, asynchronous active-high clear.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regwrite_i,
  input  logic [ADDR_WIDTH-1:0] wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  input  logic [ADDR_WIDTH-1:0] ra0_i,
  input  logic [ADDR_WIDTH-1:0] ra1_i,
  output logic [DATA_WIDTH-1:0] rd0_o,
  output logic [DATA_WIDTH-1:0] rd1_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_we;

  // rst_n is active-high despite its name.
  assign w_we = regwrite_i && (wa_i != '0);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[wa_i] <= wd_i;
    end
  end

  // No write-through: a pending write is invisible until its edge commits it.
  assign rd0_o = (ra0_i == '0) ? '0 : r_mem[ra0_i];
  assign rd1_o = (ra1_i == '0) ? '0 : r_mem[ra1_i];
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, hand-written corner
// sequences and randomized traffic against an array-based reference model.
`timescale 1ns/100ps
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwrite_i;
  logic [4:0]  wa_i, ra0_i, ra1_i;
  logic [31:0] wd_i, rd0_o, rd1_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [32];

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .regwrite_i(regwrite_i), .wa_i(wa_i), .wd_i(wd_i),
    .ra0_i(ra0_i), .ra1_i(ra1_i), .rd0_o(rd0_o), .rd1_o(rd1_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // One write cycle: drive at negedge, commit at posedge, update the model.
  task automatic wr(input logic we, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    regwrite_i = we; wa_i = a; wd_i = d;
    @(posedge clk);
    #1;
    regwrite_i = 1'b0;
    if (we && a != 0) model[a] = d;
  endtask

  task automatic rd_check(input string name, input logic [4:0] a0, input logic [4:0] a1);
    ra0_i = a0; ra1_i = a1;
    #1;
    check({name, "_rd0"}, rd0_o, model[a0]);
    check({name, "_rd1"}, rd1_o, model[a1]);
  endtask

  vec_t vecs[6];

  initial begin
    rst_n = 1'b1; regwrite_i = 1'b0; wa_i = '0; wd_i = '0; ra0_i = '0; ra1_i = '0;
    model_clear();
    #12 rst_n = 1'b0;

    // Dirty a register, then a 1 ns reset pulse between clock edges.
    wr(1'b1, 5'd3, 32'h0BAD_F00D);
    @(negedge clk);
    rst_n = 1'b1; #1; rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      ra0_i = 5'(i); ra1_i = 5'(31 - i);
      #0.2;
      if (i == 3 || i == 28) begin
        check("reset_rd0", rd0_o, 32'h0);
        check("reset_rd1", rd1_o, 32'h0);
      end else if (rd0_o !== 0 || rd1_o !== 0) begin
        check("reset_sweep", rd0_o | rd1_o, 32'h0);
      end
    end

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd7,  32'hAAAA5555, 5'd7,  5'd7,  32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd9,  32'h00000001, 5'd9,  5'd31, 32'h1,        32'h12345678};
    vecs[5] = '{1'b1, 5'd5,  32'hCAFEBABE, 5'd5,  5'd5,  32'hCAFEBABE, 32'hCAFEBABE};
    for (int v = 0; v < 6; v++) begin
      wr(vecs[v].we, vecs[v].wa, vecs[v].wd);
      ra0_i = vecs[v].ra0; ra1_i = vecs[v].ra1;
      #1;
      check($sformatf("vec%0d_rd0", v), rd0_o, vecs[v].exp0);
      check($sformatf("vec%0d_rd1", v), rd1_o, vecs[v].exp1);
    end

    // No bypass: a pending write to r9 is invisible until its edge.
    @(negedge clk);
    regwrite_i = 1'b1; wa_i = 5'd9; wd_i = 32'h2; ra0_i = 5'd9; ra1_i = 5'd9;
    #1;
    check("nobypass_rd0", rd0_o, 32'h1);
    check("nobypass_rd1", rd1_o, 32'h1);
    @(posedge clk); #1;
    regwrite_i = 1'b0; model[9] = 32'h2;
    check("commit_rd0", rd0_o, 32'h2);
    check("commit_rd1", rd1_o, 32'h2);

    // Back-to-back writes to one address keep the last value.
    wr(1'b1, 5'd12, 32'h1111_1111);
    wr(1'b1, 5'd12, 32'h2222_2222);
    rd_check("b2b", 5'd12, 5'd12);

    // Randomized traffic; reads checked before and after each edge.
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      we = 1'($urandom_range(0, 3) != 0);
      a  = 5'($urandom_range(0, 31));
      d  = $urandom;
      @(negedge clk);
      regwrite_i = we; wa_i = a; wd_i = d;
      ra0_i = (n % 4 == 0) ? a : 5'($urandom_range(0, 31));
      ra1_i = 5'($urandom_range(0, 31));
      #1;
      check("rand_pre_rd0", rd0_o, model[ra0_i]);
      check("rand_pre_rd1", rd1_o, model[ra1_i]);
      @(posedge clk); #1;
      if (we && a != 0) model[a] = d;
      check("rand_post_rd0", rd0_o, model[ra0_i]);
      check("rand_post_rd1", rd1_o, model[ra1_i]);
    end
    regwrite_i = 1'b0;

    // Fill r1..r31 with nonzero data, then reset asynchronously mid-cycle.
    for (int i = 1; i < 32; i++) wr(1'b1, 5'(i), 32'h8000_0000 | 32'(i));
    rd_check("filled", 5'd1, 5'd31);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #0.5;
    check("async_rst_rd0", rd0_o, 32'h0);
    check("async_rst_rd1", rd1_o, 32'h0);
    model_clear();
    // Hold reset across an edge with a write presented: it must be ignored.
    regwrite_i = 1'b1; wa_i = 5'd2; wd_i = 32'h7777_7777;
    @(posedge clk);
    @(negedge clk);
    regwrite_i = 1'b0;
    rst_n = 1'b0;
    rd_check("rst_held_wr", 5'd2, 5'd17);
    wr(1'b1, 5'd4, 32'h0000_0055);
    rd_check("post_rst_wr", 5'd4, 5'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Whole-run safety bound.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
